// File: rtl/adder_tree_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_scheduler_pkg
// Shared constants for the scheduled eight-input adder tree.
//   OPERANDS   : number of operands reduced per request (8)
//   TREE_DEPTH : number of pairwise adder levels (3)
//   sum_width  : full-precision result width for a given operand width
// -----------------------------------------------------------------------------
package adder_tree_scheduler_pkg;

   localparam int OPERANDS   = 8;
   localparam int TREE_DEPTH = 3;

   // Each adder level can grow the value by one bit, so three levels need
   // three extra bits for the sum to never wrap.
   function automatic int sum_width(input int adder_width);
      return adder_width + TREE_DEPTH;
   endfunction

endpackage

// File: rtl/adder_tree_reduce.sv
// -----------------------------------------------------------------------------
// adder_tree_reduce
// Purely combinational 8-to-1 unsigned adder tree.
// Ports:
//   operands : OPERANDS*ADDER_WIDTH packed operands, operand k at slice k
//   sum      : ADDER_WIDTH+3 bit full-precision sum
// -----------------------------------------------------------------------------
module adder_tree_reduce
   import adder_tree_scheduler_pkg::*;
#(
   parameter int ADDER_WIDTH = 13
)
(
   input  logic [OPERANDS*ADDER_WIDTH-1:0]   operands,
   output logic [sum_width(ADDER_WIDTH)-1:0] sum
);

   localparam int W = ADDER_WIDTH;

   logic [W:0]   level1 [4];
   logic [W+1:0] level2 [2];

   // Every level zero-extends its inputs by one bit so no carry is lost.
   for (genvar i = 0; i < 4; i++) begin : g_level1
      assign level1[i] = {1'b0, operands[2*i*W +: W]} + {1'b0, operands[(2*i+1)*W +: W]};
   end

   for (genvar i = 0; i < 2; i++) begin : g_level2
      assign level2[i] = {1'b0, level1[2*i]} + {1'b0, level1[2*i+1]};
   end

   assign sum = {1'b0, level2[0]} + {1'b0, level2[1]};

endmodule

// File: rtl/adder_tree_scheduler.sv
// -----------------------------------------------------------------------------
// adder_tree_scheduler
// Round-robin scheduler sharing one eight-input adder tree among NUM_REQ
// requesters, with a one-stage operand register and a credit-protected
// result FIFO.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_data            : eight operands per requester, requester r at slice r
//   res_valid/res_ready : result FIFO head handshake
//   res_sum, res_id     : head sum and originating requester (0 when empty)
//   busy                : stage register or FIFO holds data
// -----------------------------------------------------------------------------
module adder_tree_scheduler
   import adder_tree_scheduler_pkg::*;
#(
   parameter int ADDER_WIDTH = 13,
   parameter int NUM_REQ     = 4,
   parameter int FIFO_DEPTH  = 4,
   localparam int SUM_W      = sum_width(ADDER_WIDTH),
   localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   input  logic [NUM_REQ*OPERANDS*ADDER_WIDTH-1:0] req_data,
   output logic                                  res_valid,
   input  logic                                  res_ready,
   output logic [SUM_W-1:0]                      res_sum,
   output logic [ID_W-1:0]                       res_id,
   output logic                                  busy
);

   localparam int SET_W = OPERANDS * ADDER_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [ID_W-1:0]  rr_ptr;
   logic             stage_valid;
   logic [SET_W-1:0] stage_data;
   logic [ID_W-1:0]  stage_id;
   logic [SUM_W-1:0] tree_sum;

   logic [SUM_W-1:0] fifo_sum [FIFO_DEPTH];
   logic [ID_W-1:0]  fifo_id  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;

   logic [OCC_W-1:0] occupancy;
   logic             credit_ok;
   logic             grant_found;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  arb_idx;
   logic [SET_W-1:0] grant_data;
   logic             transfer;
   logic             push;
   logic             pop;

   // A result that is in the stage register already owns a FIFO slot, so the
   // credit check counts it; only registered state feeds this, which keeps
   // res_ready out of the req_ready path.
   assign occupancy = OCC_W'(fifo_count) + OCC_W'(stage_valid);
   assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);

   // Walk the requesters starting at rr_ptr, wrapping at NUM_REQ, and take
   // the first one that is valid.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      arb_idx     = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[arb_idx]) begin
            grant_found = 1'b1;
            grant_id    = arb_idx;
         end
         arb_idx = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
   end

   // Operand set of the granted requester.
   always_comb begin
      grant_data = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant_id == ID_W'(r)) begin
            grant_data = req_data[r*SET_W +: SET_W];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_found && credit_ok) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   assign transfer  = grant_found & credit_ok;
   assign push      = stage_valid;
   assign res_valid = (fifo_count != '0);
   assign pop       = res_valid & res_ready;
   assign busy      = stage_valid | res_valid;

   adder_tree_reduce #(
      .ADDER_WIDTH (ADDER_WIDTH)
   ) u_reduce (
      .operands (stage_data),
      .sum      (tree_sum)
   );

   // Arbiter pointer, stage register and FIFO bookkeeping. The stage always
   // drains into the FIFO the cycle after it loads; credit guarantees space.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         stage_valid <= 1'b0;
         stage_data  <= '0;
         stage_id    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
      end else begin
         stage_valid <= transfer;
         if (transfer) begin
            stage_data <= grant_data;
            stage_id   <= grant_id;
            rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + 1'b1;
         end else if (pop && !push) begin
            fifo_count <= fifo_count - 1'b1;
         end
      end
   end

   // FIFO storage needs no reset; validity is tracked by fifo_count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_sum[wr_ptr] <= tree_sum;
         fifo_id[wr_ptr]  <= stage_id;
      end
   end

   // Outputs read as zero whenever the FIFO is empty.
   assign res_sum = res_valid ? fifo_sum[rd_ptr] : '0;
   assign res_id  = res_valid ? fifo_id[rd_ptr]  : '0;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_scheduler
// Self-checking bench: table-driven single-operation vectors, hand-written
// fairness / backpressure / full-credit / reset sequences, and randomized
// traffic, all compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_adder_tree_scheduler;

   localparam int W     = 13;
   localparam int NR    = 4;
   localparam int DEPTH = 4;
   localparam int SW    = W + 3;
   localparam int IDW   = 2;
   localparam int SETW  = 8 * W;

   logic               clk = 1'b0;
   logic               rst;
   logic [NR-1:0]      req_valid;
   logic [NR-1:0]      req_ready;
   logic [NR*SETW-1:0] req_data;
   logic               res_valid;
   logic               res_ready;
   logic [SW-1:0]      res_sum;
   logic [IDW-1:0]     res_id;
   logic               busy;

   adder_tree_scheduler #(
      .ADDER_WIDTH (W),
      .NUM_REQ     (NR),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_id    (res_id),
      .busy      (busy)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Reference model: every issued request waits in a queue until popped; it
   // becomes visible at the head two cycles after issue.
   typedef struct {
      int sum;
      int id;
      int vis;
   } exp_t;

   typedef struct packed {
      logic [7:0][W-1:0] ops;
      logic [1:0]        id;
      logic [SW-1:0]     exp_sum;
   } vec_t;

   exp_t exp_q[$];
   int   pop_ids[$];
   int   rr;
   int   cyc;
   int   n_checks;
   int   n_pass;
   bit   xfer;
   bit   popped;
   logic [NR-1:0] last_ready;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Drive the handshake inputs for the coming cycle.
   task automatic applyStimulus(input logic [NR-1:0] v, input logic rdy);
      req_valid = v;
      res_ready = rdy;
   endtask

   task automatic randomData();
      for (int r = 0; r < NR; r++) begin
         for (int k = 0; k < 8; k++) begin
            req_data[(r*8+k)*W +: W] = W'($urandom);
         end
      end
   endtask

   function automatic int modelSum(input logic [NR*SETW-1:0] d, input int r);
      int s;
      s = 0;
      for (int k = 0; k < 8; k++) begin
         s += int'(d[(r*8+k)*W +: W]);
      end
      return s;
   endfunction

   // One clock cycle: check outputs at the falling edge against the model,
   // then advance the model with the handshakes of that cycle.
   task automatic cycle();
      int            g;
      logic [NR-1:0] er;
      bit            ev;
      int            es;
      int            ei;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NR; k++) begin
         if (g < 0 && req_valid[(rr + k) % NR]) g = (rr + k) % NR;
      end
      er = '0;
      if (g >= 0 && exp_q.size() < DEPTH) er[g] = 1'b1;
      ev = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      es = ev ? exp_q[0].sum : 0;
      ei = ev ? exp_q[0].id : 0;
      last_ready = req_ready;
      checkOutput("req_ready", 32'(req_ready), 32'(er));
      checkOutput("res_valid", 32'(res_valid), 32'(ev));
      checkOutput("res_sum", 32'(res_sum), es);
      checkOutput("res_id", 32'(res_id), ei);
      checkOutput("busy", 32'(busy), 32'(exp_q.size() != 0));
      xfer   = 1'b0;
      popped = 1'b0;
      if (rst) begin
         exp_q.delete();
         rr = 0;
      end else begin
         if (ev && res_ready) begin
            popped = 1'b1;
            pop_ids.push_back(32'(res_id));
            void'(exp_q.pop_front());
         end
         if (er != '0) begin
            xfer = 1'b1;
            exp_q.push_back('{modelSum(req_data, g), g, cyc + 2});
            rr = (g + 1) % NR;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   vec_t vecs[5];
   int   xfers;
   int   bound;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      rr       = 0;
      rst      = 1'b1;
      req_data = '0;
      applyStimulus('0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      checkOutput("reset_res_valid", 32'(res_valid), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_res_sum", 32'(res_sum), 0);

      // Single-operation vectors with hand-computed sums.
      vecs[0] = '{ops: {13'd8, 13'd7, 13'd6, 13'd5, 13'd4, 13'd3, 13'd2, 13'd1}, id: 2'd2, exp_sum: 16'd36};
      vecs[1] = '{ops: {8{13'd8191}}, id: 2'd0, exp_sum: 16'd65528};
      vecs[2] = '{ops: {8{13'd0}}, id: 2'd1, exp_sum: 16'd0};
      vecs[3] = '{ops: {13'd800, 13'd700, 13'd600, 13'd500, 13'd400, 13'd300, 13'd200, 13'd100}, id: 2'd3, exp_sum: 16'd3600};
      vecs[4] = '{ops: {13'd8191, 13'd1, 13'd8191, 13'd1, 13'd8191, 13'd1, 13'd8191, 13'd1}, id: 2'd0, exp_sum: 16'd32768};

      for (int v = 0; v < 5; v++) begin
         req_data = '0;
         req_data[int'(vecs[v].id)*SETW +: SETW] = vecs[v].ops;
         applyStimulus(NR'(1) << vecs[v].id, 1'b1);
         bound = 0;
         do begin
            cycle();
            bound++;
         end while (!xfer && bound < 10);
         checkOutput("vec_transfer", 32'(xfer), 1);
         applyStimulus('0, 1'b1);
         cycle();
         checkOutput("vec_res_valid", 32'(res_valid), 1);
         checkOutput("vec_res_sum", 32'(res_sum), 32'(vecs[v].exp_sum));
         checkOutput("vec_res_id", 32'(res_id), 32'(vecs[v].id));
         cycle();
         checkOutput("vec_busy_after_pop", 32'(busy), 0);
      end

      // Backpressure: exactly DEPTH transfers, then ready stays low.
      randomData();
      applyStimulus(4'b0010, 1'b0);
      xfers = 0;
      for (int c = 0; c < 8; c++) begin
         cycle();
         if (last_ready[1]) xfers++;
      end
      checkOutput("bp_transfers", 32'(xfers), DEPTH);
      pop_ids.delete();
      applyStimulus(4'b0010, 1'b1);
      xfers = 0;
      for (int c = 0; c < 8; c++) begin
         randomData();
         cycle();
         if (last_ready[1]) xfers++;
      end
      checkOutput("bp_pops", 32'(pop_ids.size() >= DEPTH), 1);
      checkOutput("bp_resumed", 32'(xfers > 0), 1);

      // Drain, then fill to full credit and pop/push in the same cycle.
      applyStimulus('0, 1'b1);
      bound = 0;
      while (exp_q.size() != 0 && bound < 20) begin
         cycle();
         bound++;
      end
      checkOutput("drain_empty", 32'(exp_q.size()), 0);
      applyStimulus(4'b0100, 1'b0);
      for (int c = 0; c < 4; c++) begin
         randomData();
         cycle();
      end
      applyStimulus(4'b0100, 1'b1);
      checkOutput("full_ready_low", 32'(req_ready), 0);
      cycle();
      checkOutput("full_busy", 32'(busy), 1);
      checkOutput("full_outstanding", 32'(exp_q.size()), 3);
      applyStimulus('0, 1'b1);
      for (int c = 0; c < 8; c++) cycle();

      // Reset mid-flight: two buffered, one in flight.
      applyStimulus(4'b1000, 1'b0);
      for (int c = 0; c < 3; c++) begin
         randomData();
         cycle();
      end
      applyStimulus('0, 1'b0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checkOutput("rst_res_valid", 32'(res_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);

      // Fairness from a freshly reset pointer: grants 0,1,2,3,...
      pop_ids.delete();
      applyStimulus('1, 1'b1);
      for (int c = 0; c < 12; c++) begin
         randomData();
         cycle();
         checkOutput("fair_grant", 32'(last_ready), 32'(NR'(1) << (c % NR)));
      end
      for (int i = 0; i < 8; i++) begin
         checkOutput("fair_res_id", (i < pop_ids.size()) ? pop_ids[i] : -1, i % NR);
      end

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         randomData();
         applyStimulus(NR'($urandom), ($urandom_range(0, 9) < 7));
         cycle();
      end
      applyStimulus('0, 1'b1);
      for (int c = 0; c < 10; c++) cycle();
      checkOutput("final_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adder_tree_scheduler.md
ADDER_TREE_SCHEDULER -- requirements
Module: adder_tree_scheduler

Interface
REQ-001 Parameter ADDER_WIDTH, default 13, operand width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters sharing the 8-input adder tree.
REQ-003 Parameter FIFO_DEPTH, default 4, result FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operand-set valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_data  input  NUM_REQ*8*ADDER_WIDTH  eight unsigned operands per requester; requester r at slice r, operand k at sub-slice k.
REQ-009 res_valid  output  1  result FIFO head valid.
REQ-010 res_ready  input  1  consumer accepts head.
REQ-011 res_sum  output  ADDER_WIDTH+3  full-precision sum of eight operands.
REQ-012 res_id  output  clog2(NUM_REQ), min 1  index of the originating requester.
REQ-013 busy  output  1  high when a tree stage or the FIFO holds data.

Function
REQ-014 Issue per cycle: at most one; transfer on req_valid[r] & req_ready[r].
REQ-015 Arbitration: round-robin starting at pointer rr_ptr; grant the first valid requester at or after rr_ptr, modulo NUM_REQ.
REQ-016 After a transfer from requester g, rr_ptr becomes (g+1) mod NUM_REQ; no transfer leaves rr_ptr unchanged.
REQ-017 Credit rule: req_ready is all-zero when fifo_count + inflight >= FIFO_DEPTH, using registered values only; no combinational path from res_ready to req_ready.
REQ-018 req_ready depends only on req_valid and registered state; a requester sees req_ready only while its req_valid is high.
REQ-019 Pipeline: transfer in cycle t loads operands and id into the stage register (inflight=1 in t+1); the tree sum is written into the FIFO at the end of t+1; res_valid is visible no earlier than t+2.
REQ-020 Arithmetic: unsigned, zero-extended; pairwise widths ADDER_WIDTH+1, +2, +3; no truncation, no overflow possible.
REQ-021 FIFO pop on res_valid & res_ready; push and pop in the same cycle are both honoured; count unchanged.
REQ-022 Results leave in issue order; res_sum/res_id hold stable while res_valid & !res_ready.
REQ-023 res_id for each result equals the index granted at its issue.
REQ-024 With res_ready held high, one requester continuously valid is accepted every cycle (full throughput).
REQ-025 busy = inflight | (fifo_count != 0).

Reset
REQ-026 rst high: rr_ptr=0, inflight=0, FIFO empty, pointers 0; req_ready=0, res_valid=0, busy=0 in the following cycle.
REQ-027 Reset asserted mid-operation discards in-flight and buffered results; no result issued before reset is ever presented after it.
REQ-028 res_sum and res_id read as 0 while res_valid is 0 after reset.

Structure
REQ-029 A shared package holds the constant OPERANDS=8, tree depth 3, and the sum-width function ADDER_WIDTH+3.
REQ-030 The 8-input reduction is a sub-module adder_tree_reduce (purely combinational, parameterised by ADDER_WIDTH); the arbiter, stage register, credit logic and FIFO live in adder_tree_scheduler.

Verification
REQ-031 Single op: req 2 presents operands 1..8, res_ready=1 -> res_valid two cycles after transfer, res_sum=36, res_id=2, busy low the cycle after pop.
REQ-032 Max values: all operands 8191 -> res_sum=65528 (16 bits), no wrap.
REQ-033 Fairness: all four requesters valid continuously, res_ready=1 -> grants in order 0,1,2,3,0,... one per cycle; res_id sequence matches.
REQ-034 Backpressure: res_ready=0, one requester valid -> exactly 4 transfers, then req_ready stays 0; raise res_ready -> 4 results in order, issues resume.
REQ-035 Simultaneous push/pop at full credit: FIFO at 3 entries, inflight 1, pop and new push in same cycle -> count stays 4, no loss, no duplicate.
REQ-036 Reset mid-flight: 2 results buffered and 1 in flight, pulse rst one cycle -> res_valid=0, rr_ptr=0; the next issue from requester 0 is the first result seen.
